// File: rtl/pseudo_spi_capture.sv
// Scan-chain readback: captures PIN into the chain, shifts it out via SI, packs LSB-first bytes into SRAM.
// Optional PSEUDO_SPI_CAPTURE_FREQ_DIV_EN adds FREQ_DIV to stretch every CAPT/SHIFT phase to FREQ_DIV+1 clocks.
module pseudo_spi_capture #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         rst_n,
`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
  input  logic [7:0]                   FREQ_DIV,
`endif
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_END,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         spi_is_done
);

  localparam int BIT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MEMORY_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    SHIFT,
    WRITE,
    LOOP,
    DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     phase_q, phase_d;
  logic [BIT_W-1:0]               bitCnt_q, bitCnt_d;
  logic [RESERVED_DATA_LEN-1:0]   byteCnt_q, byteCnt_d;
  logic [MEMORY_ADDR_WIDTH-1:0]   addrCnt_q, addrCnt_d;
  logic [MEMORY_DATA_WIDTH-1:0]   shiftReg_q, shiftReg_d;
  logic                           phaseEnd;

`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
  logic [7:0] freqDiv_q, freqDiv_d;
  logic [7:0] divCnt_q, divCnt_d;

  assign phaseEnd = (divCnt_q == freqDiv_q);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      freqDiv_q <= '0;
      divCnt_q  <= '0;
    end else begin
      freqDiv_q <= freqDiv_d;
      divCnt_q  <= divCnt_d;
    end
  end
`else
  assign phaseEnd = 1'b1;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bitCnt_q   <= '0;
      byteCnt_q  <= '0;
      addrCnt_q  <= '0;
      shiftReg_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitCnt_q   <= bitCnt_d;
      byteCnt_q  <= byteCnt_d;
      addrCnt_q  <= addrCnt_d;
      shiftReg_q <= shiftReg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitCnt_d    = bitCnt_q;
    byteCnt_d   = byteCnt_q;
    addrCnt_d   = addrCnt_q;
    shiftReg_d  = shiftReg_q;
    SCLK1       = 1'b0;
    SCLK2       = 1'b0;
    SEL         = 1'b0;
    CEN         = 1'b1;
    WEN         = 1'b1;
    spi_is_done = 1'b0;
`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
    freqDiv_d = freqDiv_q;
    divCnt_d  = divCnt_q;
    if (state_q == CAPT || state_q == SHIFT) begin
      divCnt_d = phaseEnd ? 8'd0 : divCnt_q + 8'd1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (BGN) begin
          addrCnt_d = ADDR_END;
          byteCnt_d = DATA_LEN;
          bitCnt_d  = '0;
          phase_d   = '0;
          state_d   = CAPT;
`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
          freqDiv_d = FREQ_DIV;
          divCnt_d  = '0;
`endif
        end
      end

      CAPT: begin
        SEL   = 1'b1;
        SCLK1 = (phase_q == 2'd0);
        SCLK2 = (phase_q == 2'd2);
        if (phaseEnd) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d = SHIFT;
          end
        end
      end

      // Sample before pulsing so the first bit is the captured last-cell value.
      SHIFT: begin
        SCLK1 = (phase_q == 2'd1);
        SCLK2 = (phase_q == 2'd3);
        if (phaseEnd) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd0) begin
            shiftReg_d = {SI, shiftReg_q[MEMORY_DATA_WIDTH-1:1]};
          end
          if (phase_q == 2'd3) begin
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = '0;
              state_d  = WRITE;
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end
        end
      end

      WRITE: begin
        CEN     = 1'b0;
        WEN     = 1'b0;
        state_d = LOOP;
      end

      LOOP: begin
        addrCnt_d = addrCnt_q - 1'b1;
        if (byteCnt_q == '0) begin
          state_d = DONE;
        end else begin
          byteCnt_d = byteCnt_q - 1'b1;
          state_d   = SHIFT;
        end
      end

      DONE: begin
        spi_is_done = 1'b1;
        if (!BGN) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign A = addrCnt_q;
  assign D = shiftReg_q;

endmodule

// File: tb/tb_pseudo_spi_capture.sv
// Self-checking bench: a master/slave scan-chain model feeds SI, an SRAM-port monitor logs writes,
// and expected bytes/addresses/latencies come from the stream arithmetic of the captured PIN word.
module tb_pseudo_spi_capture;

`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       rst_n;
   logic [7:0] FREQ_DIV;
   logic       BGN;
   logic [8:0] ADDR_END;
   logic [7:0] DATA_LEN;
   logic       SI;
   logic       SCLK1, SCLK2, SEL, CEN, WEN, spi_is_done;
   logic [8:0] A;
   logic [7:0] D;

   int errorCount = 0;
   int checkCount = 0;

   // Scan chain of 32 cells, cell 0 nearest SO, serial input tied low
   logic [31:0] pinBus = '0;
   logic [31:0] chainMaster = '0;
   logic [31:0] chainSlave = '0;

   logic [8:0] wrAddrQ[$];
   logic [7:0] wrDataQ[$];
   int cenLowCycles = 0;
   int selHighCycles = 0;
   int clockErrs = 0;
   logic prevS1 = 1'b0;
   logic prevS2 = 1'b0;

   always #5 CLK = ~CLK;

   assign SI = chainSlave[0];

   pseudo_spi_capture dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
`ifdef PSEUDO_SPI_CAPTURE_FREQ_DIV_EN
      .FREQ_DIV    (FREQ_DIV),
`endif
      .BGN         (BGN),
      .ADDR_END    (ADDR_END),
      .DATA_LEN    (DATA_LEN),
      .SI          (SI),
      .SCLK1       (SCLK1),
      .SCLK2       (SCLK2),
      .SEL         (SEL),
      .CEN         (CEN),
      .WEN         (WEN),
      .A           (A),
      .D           (D),
      .spi_is_done (spi_is_done)
   );

   // Chain behaviour and SRAM-port / scan-clock protocol monitor, sampled mid-cycle
   always @(negedge CLK) begin
      if (SCLK1) chainMaster = SEL ? pinBus : {1'b0, chainSlave[31:1]};
      if (SCLK2) chainSlave = chainMaster;
      if (SCLK1 && SCLK2) clockErrs++;
      if ((SCLK1 && prevS2) || (SCLK2 && prevS1)) clockErrs++;
      prevS1 = SCLK1;
      prevS2 = SCLK2;
      if (SEL) selHighCycles++;
      if (!CEN) begin
         cenLowCycles++;
         if (!WEN) begin
            wrAddrQ.push_back(A);
            wrDataQ.push_back(D);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_sclk1"}, 32'(SCLK1), 32'd0);
      checkOutput({tag, "_sclk2"}, 32'(SCLK2), 32'd0);
      checkOutput({tag, "_sel"}, 32'(SEL), 32'd0);
      checkOutput({tag, "_cen"}, 32'(CEN), 32'd1);
      checkOutput({tag, "_wen"}, 32'(WEN), 32'd1);
      checkOutput({tag, "_a"}, 32'(A), 32'd0);
      checkOutput({tag, "_d"}, 32'(D), 32'd0);
      checkOutput({tag, "_done"}, 32'(spi_is_done), 32'd0);
   endtask

   task automatic clearMonitor();
      wrAddrQ.delete();
      wrDataQ.delete();
      cenLowCycles = 0;
      selHighCycles = 0;
      clockErrs = 0;
   endtask

   // One full transfer: start, scramble the (ignored) setup inputs, measure latency, hold, release, verify writes
   task automatic applyStimulus(input logic [31:0] pin, input logic [8:0] addrEnd, input logic [7:0] len,
                                input logic [7:0] fdiv, input int holdCycles);
      int phaseLen;
      int expLatency;
      int cycles;
      int doneDrops;
      logic [63:0] stream;
      phaseLen = DIV_EN ? int'(fdiv) + 1 : 1;
      expLatency = 36 * phaseLen + 2 + int'(len) * (32 * phaseLen + 2);
      stream = {32'd0, pin};

      @(negedge CLK);
      #1;
      clearMonitor();
      pinBus = pin;
      ADDR_END = addrEnd;
      DATA_LEN = len;
      FREQ_DIV = fdiv;
      BGN = 1'b1;
      @(posedge CLK);
      #1;
      ADDR_END = 9'($urandom);
      DATA_LEN = 8'($urandom);
      FREQ_DIV = 8'($urandom);
      cycles = 0;
      while (!spi_is_done && cycles < expLatency + 200) begin
         @(posedge CLK);
         cycles++;
         #1;
      end
      checkOutput("latency", 32'(cycles), 32'(expLatency));

      doneDrops = 0;
      repeat (holdCycles) begin
         @(negedge CLK);
         if (!spi_is_done) doneDrops++;
      end
      checkOutput("done_held", 32'(doneDrops), 32'd0);

      @(negedge CLK);
      BGN = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("done_release", 32'(spi_is_done), 32'd0);

      checkOutput("capture_cycles", 32'(selHighCycles), 32'(4 * phaseLen));
      checkOutput("write_count", 32'(wrAddrQ.size()), 32'(int'(len) + 1));
      checkOutput("cen_low_cycles", 32'(cenLowCycles), 32'(int'(len) + 1));
      checkOutput("clock_protocol", 32'(clockErrs), 32'd0);
      for (int i = 0; i <= int'(len); i++) begin
         if (i < wrAddrQ.size()) begin
            checkOutput($sformatf("addr[%0d]", i), 32'(wrAddrQ[i]), 32'(9'(addrEnd - 9'(i))));
            checkOutput($sformatf("data[%0d]", i), 32'(wrDataQ[i]), 32'(8'(stream >> (8 * i))));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      BGN = 1'b0;
      ADDR_END = '0;
      DATA_LEN = '0;
      FREQ_DIV = '0;
      #3;
      checkIdleOutputs("reset");
      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
      checkIdleOutputs("idle");

      $display("[TB] two bytes from 16-bit PIN C3A5");
      applyStimulus(32'h0000_C3A5, 9'h001, 8'd1, 8'd0, 0);

      $display("[TB] single byte at 0x010");
      applyStimulus(32'h0000_003C, 9'h010, 8'd0, 8'd0, 0);

      $display("[TB] address wrap below zero");
      applyStimulus(32'h1234_5678, 9'h001, 8'd3, 8'd0, 0);

      $display("[TB] reset during fifth bit of byte 0");
      @(negedge CLK);
      #1;
      clearMonitor();
      pinBus = 32'hDEAD_BEEF;
      ADDR_END = 9'h055;
      DATA_LEN = 8'd2;
      BGN = 1'b1;
      @(posedge CLK);
      repeat (21) @(posedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("midreset");
      BGN = 1'b0;
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
      checkOutput("midreset_writes", 32'(wrAddrQ.size()), 32'd0);
      applyStimulus(32'h0BAD_F00D, 9'h100, 8'd2, 8'd0, 0);

      $display("[TB] BGN held through DONE");
      applyStimulus(32'h0000_5AA5, 9'h1F0, 8'd0, 8'd0, 50);

      $display("[TB] divided single byte");
      applyStimulus(32'h0000_0081, 9'h0AA, 8'd0, 8'd2, 3);

      $display("[TB] randomized transfers");
      for (int n = 0; n < 8; n++) begin
         applyStimulus($urandom, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 5)),
                       8'($urandom_range(0, 3)), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
